fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Parametrised instruction-fetch front end for the pipelined core, replacing the single-cycle PC/adder/PC-mux path.
- Holds the PC and drives the asynchronous-read instruction memory.
- Registers the fetched instruction into the IF/ID pipeline register with stall, flush and EX-stage redirect support.
- Optionally applies static backward-taken branch prediction, and keeps saturating fetch/flush statistics counters.

Parameters:
- PC_W, 9, PC / byte-address width; all PC arithmetic is modulo 2^PC_W.
- INS_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.
- CNT_W, 16, width of the statistics counters.
- NOP_INSTR, 32'h00000013, instruction placed in IF/ID on reset or flush (addi x0,x0,0).

Ports:
- clk  in  1  global clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  hazard-unit stall; hold PC and IF/ID.
- ex_redirect  in  1  EX resolved a taken jump/branch, a JALR, or a misprediction; load ex_target.
- ex_target  in  PC_W  redirect byte address from EX.
- imem_addr  out  PC_W  byte address to instruction memory (= pc).
- imem_rdata  in  INS_W  instruction word, combinational from imem_addr.
- pc  out  PC_W  current fetch PC.
- id_valid  out  1  IF/ID holds a real instruction.
- id_pc  out  PC_W  PC of the IF/ID instruction.
- id_pc_plus4  out  PC_W  id_pc+4, used for the JAL/JALR link value.
- id_instr  out  INS_W  IF/ID instruction.
- id_pred_taken  out  1  fetch predicted this instruction taken.
- fetch_cnt  out  CNT_W  instructions accepted into IF/ID.
- flush_cnt  out  CNT_W  redirects taken.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC.
  - id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0, id_pred_taken=0.
  - Both counters=0.
  - Takes effect immediately, including mid-stall or mid-redirect.
- Address path: imem_addr=pc at all times. pc_plus4 = pc+4, wrapping modulo 2^PC_W.
- Next-PC priority, evaluated every rising edge:
  1. ex_redirect=1: pc <= {ex_target[PC_W-1:2],2'b00}; the low two bits are forced to 0, covering the JALR LSB clear and word alignment.
  2. stall=1: pc holds.
  3. pred_taken=1 (optional feature only): pc <= pred_target.
  4. Otherwise: pc <= pc_plus4.
- IF/ID register, same priority:
  1. ex_redirect=1: flush. id_valid<=0, id_instr<=NOP_INSTR, id_pred_taken<=0; id_pc and id_pc_plus4 hold. Redirect overrides a simultaneous stall.
  2. stall=1: all IF/ID fields hold.
  3. Otherwise capture: id_valid<=1, id_instr<=imem_rdata, id_pc<=pc, id_pc_plus4<=pc_plus4, id_pred_taken<=pred_taken.
- Latency: one cycle PC-to-IF/ID. The first valid instruction (at RESET_PC) appears after the first rising edge following reset release. After a redirect, the target instruction is in IF/ID one cycle after the redirect edge, so each redirect costs 1 bubble.
- Wrap-around: pc=2^PC_W-4 with no stall or redirect gives next pc=0.
- Counters:
  - fetch_cnt +1 on every capture edge.
  - flush_cnt +1 on every edge with ex_redirect=1, whether or not stall is also asserted.
  - Both saturate at all-ones and never wrap.
- Correctness of ex_redirect, including misprediction detection using id_pred_taken, is EX's responsibility. This block obeys ex_redirect unconditionally.

Optional Feature:
- Macro: FETCH_BTFN_PRED_EN.
- Defined: combinational pre-decode of imem_rdata.
  - opcode 1101111 (JAL): pred_taken=1, pred_target = pc + sign-extended J-immediate, truncated to PC_W.
  - opcode 1100011 (branch) with instr[31]=1 (backward offset): pred_taken=1, pred_target = pc + sign-extended B-immediate.
  - Forward branches and JALR: pred_taken=0.
  - Prediction is suppressed on cycles with stall or ex_redirect.
- Undefined: pred_taken tied 0, pre-decode logic absent, id_pred_taken always 0. Every control transfer is resolved through ex_redirect.

Test Plan:
- Reset release with RESET_PC=0, straight-line code 0x00,0x04,0x08 -> id_pc sequence 0,4,8 on consecutive edges; id_valid=1 from the first edge; fetch_cnt=3.
- stall=1 for 2 cycles while pc=0x10 -> pc and id_instr hold for 2 cycles; fetch_cnt unchanged; resumes at 0x14.
- ex_redirect=1 with ex_target=0x43 and stall=1 simultaneously -> pc=0x40; id_valid=0 and id_instr=0x00000013 next cycle; flush_cnt=1; instruction at 0x40 in IF/ID the following cycle.
- PC_W=9, pc=0x1FC, no stall -> next pc=0x000, id_pc_plus4=0x000 for the 0x1FC instruction.
- FETCH_BTFN_PRED_EN, beq at 0x20 with offset -8 -> next pc=0x18, id_pred_taken=1. Forward beq with offset +8 -> next pc=0x24, id_pred_taken=0. JAL with offset +0x40 at 0x20 -> next pc=0x60.
- reset driven low mid-stream at pc=0x80 between clock edges -> pc=0, id_valid=0 and counters=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, IF/ID pipeline register, and saturating fetch/flush counters.
// Define FETCH_BTFN_PRED_EN to enable static backward-taken/forward-not-taken prediction.
module fetch_stage #(
  parameter int                PC_W      = 9,
  parameter int                INS_W     = 32,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  parameter int                CNT_W     = 16,
  parameter logic [INS_W-1:0]  NOP_INSTR = 'h13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              ex_redirect,
  input  logic [PC_W-1:0]   ex_target,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INS_W-1:0]  imem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              id_valid,
  output logic [PC_W-1:0]   id_pc,
  output logic [PC_W-1:0]   id_pc_plus4,
  output logic [INS_W-1:0]  id_instr,
  output logic              id_pred_taken,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [PC_W-1:0]  r_pc;
  logic             r_id_valid;
  logic [PC_W-1:0]  r_id_pc;
  logic [PC_W-1:0]  r_id_pc_plus4;
  logic [INS_W-1:0] r_id_instr;
  logic             r_id_pred_taken;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [PC_W-1:0]  w_pc_plus4;
  logic [PC_W-1:0]  w_redirect_pc;
  logic [PC_W-1:0]  w_pred_target;
  logic [PC_W-1:0]  w_pc_next;
  logic             w_pred_taken;
  logic             w_capture;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_pc_plus4    = r_pc + PC_W'(4);
  // Clearing the low two bits covers both the JALR LSB clear and word alignment.
  assign w_redirect_pc = ex_target & ~PC_W'(3);
  assign w_capture     = !ex_redirect && !stall;

`ifdef FETCH_BTFN_PRED_EN
  logic [6:0]         w_opcode;
  logic signed [31:0] w_jimm;
  logic signed [31:0] w_bimm;

  assign w_opcode = imem_rdata[6:0];
  assign w_jimm   = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                     imem_rdata[30:21], 1'b0};
  assign w_bimm   = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                     imem_rdata[11:8], 1'b0};

  always_comb begin
    w_pred_taken  = 1'b0;
    w_pred_target = w_pc_plus4;
    if (w_capture) begin
      if (w_opcode == 7'b1101111) begin
        w_pred_taken  = 1'b1;
        w_pred_target = r_pc + w_jimm[PC_W-1:0];
      end else if (w_opcode == 7'b1100011 && imem_rdata[31]) begin
        w_pred_taken  = 1'b1;
        w_pred_target = r_pc + w_bimm[PC_W-1:0];
      end
    end
  end
`else
  assign w_pred_taken  = 1'b0;
  assign w_pred_target = w_pc_plus4;
`endif

  always_comb begin
    w_pc_next = r_pc;
    if (ex_redirect) begin
      w_pc_next = w_redirect_pc;
    end else if (stall) begin
      w_pc_next = r_pc;
    end else if (w_pred_taken) begin
      w_pc_next = w_pred_target;
    end else begin
      w_pc_next = w_pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc            <= RESET_PC;
      r_id_valid      <= 1'b0;
      r_id_pc         <= '0;
      r_id_pc_plus4   <= '0;
      r_id_instr      <= NOP_INSTR;
      r_id_pred_taken <= 1'b0;
      r_fetch_cnt     <= '0;
      r_flush_cnt     <= '0;
    end else begin
      r_pc <= w_pc_next;
      // Redirect flushes IF/ID but keeps the stale PC fields; stall holds everything.
      if (ex_redirect) begin
        r_id_valid      <= 1'b0;
        r_id_instr      <= NOP_INSTR;
        r_id_pred_taken <= 1'b0;
        r_flush_cnt     <= sat_inc(r_flush_cnt);
      end else if (w_capture) begin
        r_id_valid      <= 1'b1;
        r_id_instr      <= imem_rdata;
        r_id_pc         <= r_pc;
        r_id_pc_plus4   <= w_pc_plus4;
        r_id_pred_taken <= w_pred_taken;
        r_fetch_cnt     <= sat_inc(r_fetch_cnt);
      end
    end
  end

  assign imem_addr     = r_pc;
  assign pc            = r_pc;
  assign id_valid      = r_id_valid;
  assign id_pc         = r_id_pc;
  assign id_pc_plus4   = r_id_pc_plus4;
  assign id_instr      = r_id_instr;
  assign id_pred_taken = r_id_pred_taken;
  assign fetch_cnt     = r_fetch_cnt;
  assign flush_cnt     = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vectors, literal expectations, and a per-cycle behavioural model.
module tb_fetch_stage;

`ifdef FETCH_BTFN_PRED_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall;
  logic        ex_redirect;
  logic [8:0]  ex_target;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [8:0]  pc;
  logic        id_valid;
  logic [8:0]  id_pc;
  logic [8:0]  id_pc_plus4;
  logic [31:0] id_instr;
  logic        id_pred_taken;
  logic [15:0] fetch_cnt;
  logic [15:0] flush_cnt;

  logic [31:0] mem [0:127];
  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model state
  int          m_pc, m_id_pc, m_id_pc4, m_fetch, m_flush;
  bit          m_valid, m_pt;
  logic [31:0] m_instr;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .ex_redirect(ex_redirect),
    .ex_target(ex_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc(pc), .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_instr(id_instr), .id_pred_taken(id_pred_taken),
    .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  assign imem_rdata = mem[7'(imem_addr >> 2)];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void predict(input logic [31:0] ins, input int pcv,
                                  output bit taken, output int tgt);
    int off;
    taken = 1'b0;
    tgt   = 0;
    off   = 0;
    if (PRED && ins[6:0] == 7'h6F) begin
      off   = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      taken = 1'b1;
    end else if (PRED && ins[6:0] == 7'h63 && ins[31]) begin
      off   = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      taken = 1'b1;
    end
    tgt = (pcv + off) & 511;
  endfunction

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    bit t;
    int tgt;
    if (!reset) begin
      m_pc = 0; m_valid = 0; m_instr = 32'h13; m_id_pc = 0; m_id_pc4 = 0;
      m_pt = 0; m_fetch = 0; m_flush = 0;
    end else if (ex_redirect) begin
      m_pc    = int'(ex_target) / 4 * 4;
      m_valid = 0; m_instr = 32'h13; m_pt = 0;
      m_flush = sat16(m_flush);
    end else if (!stall) begin
      predict(mem[m_pc / 4], m_pc, t, tgt);
      m_id_pc  = m_pc;
      m_id_pc4 = (m_pc + 4) % 512;
      m_instr  = mem[m_pc / 4];
      m_valid  = 1;
      m_pt     = t;
      m_fetch  = sat16(m_fetch);
      m_pc     = t ? tgt : (m_pc + 4) % 512;
    end
  end

  always @(negedge clk) begin
    chk("m_pc", 32'(pc), 32'(m_pc));
    chk("m_imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("m_id_valid", 32'(id_valid), 32'(m_valid));
    chk("m_id_pc", 32'(id_pc), 32'(m_id_pc));
    chk("m_id_pc_plus4", 32'(id_pc_plus4), 32'(m_id_pc4));
    chk("m_id_instr", id_instr, m_instr);
    chk("m_id_pred_taken", 32'(id_pred_taken), 32'(m_pt));
    chk("m_fetch_cnt", 32'(fetch_cnt), 32'(m_fetch));
    chk("m_flush_cnt", 32'(flush_cnt), 32'(m_flush));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [8:0] t);
    ex_redirect = 1'b1;
    ex_target   = t;
    tick();
    ex_redirect = 1'b0;
  endtask

  logic [23:0] stall_pat = 24'b0010_0110_0001_0000_1100_0100;
  logic [23:0] redir_pat = 24'b0100_0001_0000_1001_0000_0010;

  initial begin
    stall = 1'b0; ex_redirect = 1'b0; ex_target = '0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h13 | (32'(i) << 20);
    #1 reset = 1'b0;
    #11;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_instr", id_instr, 32'h13);
    chk("rst_fetch_cnt", 32'(fetch_cnt), 32'h0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'h0);
    reset = 1'b1;

    tick();
    chk("seq0_id_pc", 32'(id_pc), 32'h0);
    chk("seq0_id_valid", 32'(id_valid), 32'h1);
    chk("seq0_pc", 32'(pc), 32'h4);
    tick();
    chk("seq1_id_pc", 32'(id_pc), 32'h4);
    tick();
    chk("seq2_id_pc", 32'(id_pc), 32'h8);
    chk("seq2_fetch_cnt", 32'(fetch_cnt), 32'd3);
    tick();
    chk("pre_stall_pc", 32'(pc), 32'h10);

    stall = 1'b1;
    tick();
    chk("stall1_pc", 32'(pc), 32'h10);
    tick();
    chk("stall2_pc", 32'(pc), 32'h10);
    chk("stall2_id_instr", id_instr, 32'h0030_0013);
    chk("stall2_fetch_cnt", 32'(fetch_cnt), 32'd4);
    stall = 1'b0;
    tick();
    chk("resume_pc", 32'(pc), 32'h14);
    chk("resume_id_pc", 32'(id_pc), 32'h10);

    stall = 1'b1;
    do_redirect(9'h043);
    stall = 1'b0;
    chk("redir_pc", 32'(pc), 32'h40);
    chk("redir_id_valid", 32'(id_valid), 32'h0);
    chk("redir_id_instr", id_instr, 32'h13);
    chk("redir_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("redir_id_pc_hold", 32'(id_pc), 32'h10);
    tick();
    chk("tgt_id_pc", 32'(id_pc), 32'h40);
    chk("tgt_id_instr", id_instr, 32'h0100_0013);
    chk("tgt_id_valid", 32'(id_valid), 32'h1);

    do_redirect(9'h1F8);
    tick();
    chk("wrap_pre_pc", 32'(pc), 32'h1FC);
    tick();
    chk("wrap_pc", 32'(pc), 32'h000);
    chk("wrap_id_pc", 32'(id_pc), 32'h1FC);
    chk("wrap_id_pc_plus4", 32'(id_pc_plus4), 32'h000);

    mem[8] = 32'hFE00_0CE3;
    do_redirect(9'h020);
    chk("bback_pc0", 32'(pc), 32'h20);
    tick();
    chk("bback_pc", 32'(pc), PRED ? 32'h18 : 32'h24);
    chk("bback_pred", 32'(id_pred_taken), 32'(PRED));

    mem[8] = 32'h0000_0463;
    do_redirect(9'h020);
    tick();
    chk("bfwd_pc", 32'(pc), 32'h24);
    chk("bfwd_pred", 32'(id_pred_taken), 32'h0);

    mem[8] = 32'h0400_006F;
    do_redirect(9'h020);
    tick();
    chk("jal_pc", 32'(pc), PRED ? 32'h60 : 32'h24);
    chk("jal_pred", 32'(id_pred_taken), 32'(PRED));

    for (int i = 0; i < 24; i++) begin
      stall       = stall_pat[i];
      ex_redirect = redir_pat[i];
      ex_target   = 9'(i * 44 + 1);
      tick();
    end
    stall = 1'b0;
    ex_redirect = 1'b0;

    do_redirect(9'h07C);
    tick();
    chk("pre_areset_pc", 32'(pc), 32'h80);
    #3;
    reset = 1'b0;
    #1;
    chk("areset_pc", 32'(pc), 32'h0);
    chk("areset_id_valid", 32'(id_valid), 32'h0);
    chk("areset_fetch_cnt", 32'(fetch_cnt), 32'h0);
    chk("areset_flush_cnt", 32'(flush_cnt), 32'h0);
    tick();
    tick();
    chk("areset_hold_pc", 32'(pc), 32'h0);
    reset = 1'b1;
    tick();
    chk("post_areset_id_pc", 32'(id_pc), 32'h0);
    chk("post_areset_pc", 32'(pc), 32'h4);
    chk("post_areset_fetch_cnt", 32'(fetch_cnt), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
